// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: shared MEM-stage types, state encoding and writeback constants
package mem_stage_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_e;
  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  writereg;
    logic        regwrite;
    logic        halt;
  } wb_t;
  localparam wb_t WB_BUBBLE = '0;
  localparam wb_t WB_HALTED = '{data: 16'h0, writereg: 3'd0, regwrite: 1'b0, halt: 1'b1};
  function automatic logic [15:0] wb_data_sel(
    input logic        jumpl,
    input logic        rd_cap,
    input logic [15:0] pc_incr,
    input logic [15:0] rdata,
    input logic [15:0] alu_out
  );
    return jumpl ? pc_incr : rd_cap ? rdata : alu_out;
  endfunction
endpackage

// File: rtl/mem_stage_ctrl_pipe_memory.sv
// pipe_memory: MEM/WB register, loads a bubble when stalled and the halt marker once halted
module pipe_memory
  import mem_stage_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic stall,
  input  logic halted,
  input  wb_t  ex_wb,
  output wb_t  wb
);
  wb_t wb_d, wb_q;
  // choose halt marker, bubble or live EX/MEM data for the next writeback
  always_comb wb_d = halted ? WB_HALTED : stall ? WB_BUBBLE : ex_wb;
  // enabled register with async active-low clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) wb_q <= WB_BUBBLE;
    else if (en) wb_q <= wb_d;
  assign wb = wb_q;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage sequencing data-memory accesses, stalls and halt
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            ex_ALU_out,
  input  logic [15:0]            ex_PC_incr,
  input  logic [15:0]            ex_mem_write_data,
  input  logic                   ex_mem_read,
  input  logic                   ex_mem_write,
  input  logic                   ex_memtoreg,
  input  logic                   ex_regwrite,
  input  logic                   ex_jumpl,
  input  logic                   ex_halt,
  input  logic [2:0]             ex_writereg,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [15:0]            dmem_addr,
  output logic [15:0]            dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [15:0]            dmem_rdata,
  output logic                   stall,
  output logic [15:0]            wb_data,
  output logic [2:0]             wb_writereg,
  output logic                   wb_regwrite,
  output logic                   wb_halt,
  output logic [STALL_CNT_W-1:0] perf_stall_cnt
);
  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   access, rd_cap, halted;
  wb_t                    ex_wb, wb;
  // memory request and stall; a simultaneous read+write is treated as a write
  always_comb begin
    access     = ex_mem_read | ex_mem_write;
    rd_cap     = ex_memtoreg & ex_mem_read & ~ex_mem_write;
    halted     = state_q == HALTED;
    dmem_req   = (state_q == IDLE & access) | state_q == WAIT;
    dmem_we    = ex_mem_write;
    dmem_addr  = ex_ALU_out;
    dmem_wdata = ex_mem_write_data;
    stall      = halted | (dmem_req & ~dmem_ack);
    ex_wb      = '{data: wb_data_sel(ex_jumpl, rd_cap, ex_PC_incr, dmem_rdata, ex_ALU_out),
                   writereg: ex_writereg, regwrite: ex_regwrite, halt: ex_halt};
  end
  // next state and saturating stall counter; halted cycles are not counted
  always_comb begin
    state_d = halted ? HALTED : (!stall && ex_halt) ? HALTED : stall ? WAIT : IDLE;
    cnt_d   = (stall && !halted && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  // state and counter registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  pipe_memory u_pipe_memory (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .stall (stall),
    .halted(halted),
    .ex_wb (ex_wb),
    .wb    (wb)
  );
  assign wb_data        = wb.data;
  assign wb_writereg    = wb.writereg;
  assign wb_regwrite    = wb.regwrite;
  assign wb_halt        = wb.halt;
  assign perf_stall_cnt = cnt_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for the MEM stage controller
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;
  logic clk = 0, rst = 0;
  logic [15:0] ex_ALU_out, ex_PC_incr, ex_mem_write_data, dmem_addr, dmem_wdata, dmem_rdata, wb_data;
  logic ex_mem_read, ex_mem_write, ex_memtoreg, ex_regwrite, ex_jumpl, ex_halt;
  logic [2:0] ex_writereg, wb_writereg;
  logic dmem_req, dmem_we, dmem_ack, stall, wb_regwrite, wb_halt;
  logic [3:0] perf_stall_cnt;
  int checks = 0, errors = 0;
  wb_t q[$];
  mem_stage_ctrl #(.STALL_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ex_ALU_out(ex_ALU_out), .ex_PC_incr(ex_PC_incr),
    .ex_mem_write_data(ex_mem_write_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_jumpl(ex_jumpl), .ex_halt(ex_halt),
    .ex_writereg(ex_writereg), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_data(wb_data), .wb_writereg(wb_writereg), .wb_regwrite(wb_regwrite), .wb_halt(wb_halt),
    .perf_stall_cnt(perf_stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clear();
    {ex_mem_read, ex_mem_write, ex_memtoreg, ex_regwrite, ex_jumpl, ex_halt, dmem_ack} = '0;
    ex_writereg = 0; ex_ALU_out = 0; ex_PC_incr = 0; ex_mem_write_data = 0; dmem_rdata = 0;
  endtask
  task automatic expect_wb(input logic [15:0] d, input logic [2:0] r, input logic rw, input logic h);
    q.push_back('{data: d, writereg: r, regwrite: rw, halt: h});
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 0; clear();
    @(negedge clk); rst = 1;
  endtask
  // monitor: compare the registered writeback against the scoreboard just after each edge
  initial forever begin
    @(posedge clk); #1;
    if (q.size() != 0) begin
      wb_t e;
      e = q.pop_front();
      chk("wb", {wb_data, wb_writereg, wb_regwrite, wb_halt}, e);
    end
  end
  initial begin
    clear();
    #1;
    chk("rst_wb", {wb_data, wb_writereg, wb_regwrite, wb_halt}, 0);
    chk("rst_cnt", perf_stall_cnt, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk); rst = 1;
    // zero-wait read
    @(negedge clk);
    ex_mem_read = 1; ex_memtoreg = 1; ex_regwrite = 1; ex_writereg = 3; ex_ALU_out = 16'h0040;
    dmem_ack = 1; dmem_rdata = 16'hBEEF; #1;
    chk("zw_req", dmem_req, 1); chk("zw_stall", stall, 0);
    chk("zw_addr", dmem_addr, 16'h0040); chk("zw_we", dmem_we, 0);
    expect_wb(16'hBEEF, 3, 1, 0);
    @(negedge clk); clear(); #1;
    chk("zw_idle_req", dmem_req, 0); chk("zw_cnt", perf_stall_cnt, 0);
    expect_wb(0, 0, 0, 0);
    // read+write together behaves as a write
    @(negedge clk);
    ex_mem_read = 1; ex_mem_write = 1; ex_memtoreg = 1; ex_regwrite = 1; ex_writereg = 1;
    ex_ALU_out = 16'h0077; dmem_ack = 1; dmem_rdata = 16'hDEAD; #1;
    chk("rw_we", dmem_we, 1);
    expect_wb(16'h0077, 1, 1, 0);
    // 3-cycle write
    do_reset();
    ex_mem_write = 1; ex_ALU_out = 16'h0010; ex_mem_write_data = 16'h1234; ex_regwrite = 1; ex_writereg = 5;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("w3_stall", stall, 1); chk("w3_req", dmem_req, 1); chk("w3_we", dmem_we, 1);
      chk("w3_addr", dmem_addr, 16'h0010); chk("w3_wdata", dmem_wdata, 16'h1234);
      expect_wb(0, 0, 0, 0);
      @(negedge clk);
    end
    dmem_ack = 1; #1;
    chk("w3_stall_ack", stall, 0); chk("w3_cnt", perf_stall_cnt, 2);
    expect_wb(16'h0010, 5, 1, 0);
    @(negedge clk); clear(); #1;
    chk("w3_idle", dmem_req, 0);
    expect_wb(0, 0, 0, 0);
    // jumpl precedence
    @(negedge clk);
    ex_jumpl = 1; ex_PC_incr = 16'h0102; ex_ALU_out = 16'h0555; ex_regwrite = 1; ex_writereg = 7; #1;
    chk("jl_req", dmem_req, 0); chk("jl_stall", stall, 0);
    expect_wb(16'h0102, 7, 1, 0);
    // halt during a pending read
    do_reset();
    ex_mem_read = 1; ex_memtoreg = 1; ex_halt = 1; ex_regwrite = 1; ex_writereg = 2; ex_ALU_out = 16'h0020;
    for (int i = 0; i < 2; i++) begin
      #1; chk("h_stall", stall, 1);
      expect_wb(0, 0, 0, 0);
      @(negedge clk);
    end
    dmem_ack = 1; dmem_rdata = 16'hCAFE; #1;
    chk("h_ack_stall", stall, 0);
    expect_wb(16'hCAFE, 2, 1, 1);
    @(negedge clk);
    dmem_ack = 0; ex_halt = 0; ex_regwrite = 1; ex_writereg = 6;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("h_req", dmem_req, 0); chk("h_stall_hold", stall, 1); chk("h_cnt", perf_stall_cnt, 2);
      expect_wb(0, 0, 0, 1);
      @(negedge clk);
    end
    // reset mid-WAIT
    do_reset();
    ex_mem_write = 1; ex_ALU_out = 16'h0044; ex_regwrite = 1; ex_writereg = 4; #1;
    chk("rw_stall", stall, 1);
    expect_wb(0, 0, 0, 0);
    @(negedge clk); #1;
    chk("rw_cnt_pre", perf_stall_cnt, 1); chk("rw_wait_req", dmem_req, 1);
    ex_mem_write = 0; #1; rst = 0; #1;
    chk("rw_wb0", {wb_data, wb_writereg, wb_regwrite, wb_halt}, 0);
    chk("rw_cnt0", perf_stall_cnt, 0); chk("rw_req_drop", dmem_req, 0);
    ex_mem_write = 1; #1;
    chk("rw_req_held", dmem_req, 1);
    @(negedge clk); rst = 1; dmem_ack = 1; #1;
    chk("rw_idle_stall", stall, 0);
    expect_wb(16'h0044, 4, 1, 0);
    // counter saturation
    do_reset();
    ex_mem_write = 1; ex_ALU_out = 16'h0030;
    for (int i = 0; i < 20; i++) begin
      expect_wb(0, 0, 0, 0);
      @(negedge clk);
      if (i == 14) chk("sat_15", perf_stall_cnt, 15);
    end
    #1; chk("sat_cnt", perf_stall_cnt, 4'hF);
    dmem_ack = 1;
    expect_wb(16'h0030, 0, 0, 0);
    @(negedge clk); clear(); #1;
    chk("sat_hold", perf_stall_cnt, 4'hF);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
